// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_FAIRNESS_EN to let fetch win after STARVE_MAX consecutive data grants while it waits.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
    state_t state, state_nx;
    logic owner, owner_nx, sel_d, req, rsp, fetch_pri;
`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] starve_cnt;
    assign fetch_pri = starve_cnt == 4'(STARVE_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else if (d_gnt) starve_cnt <= !if_req ? '0 : (starve_cnt < 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
        else if (if_gnt) starve_cnt <= '0;
    end
`else
    assign fetch_pri = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        sel_d    = owner;
        req      = 1'b0;
        case (state)
            IDLE: begin
                sel_d = d_req & ~(if_req & fetch_pri);
                req   = d_req | if_req;
                if (req) begin
                    owner_nx = sel_d;
                    state_nx = mem_gnt ? WAIT : HOLD;
                end
            end
            HOLD: begin
                req      = owner ? d_req : if_req;
                state_nx = !req ? IDLE : mem_gnt ? WAIT : HOLD;
            end
            WAIT:    state_nx = mem_rvalid ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // gating with rst_n keeps every output low while reset is held, even with requests pending
    assign mem_req   = req & rst_n;
    assign mem_we    = mem_req & sel_d & d_we;
    assign mem_addr  = mem_req ? (sel_d ? d_addr : if_addr) : '0;
    assign mem_wdata = (mem_req & sel_d) ? d_wdata : '0;
    assign mem_be    = mem_req ? (sel_d ? d_be : 4'b1111) : '0;
    assign if_gnt    = mem_req & mem_gnt & ~sel_d;
    assign d_gnt     = mem_req & mem_gnt & sel_d;
    assign rsp       = (state == WAIT) & mem_rvalid;
    assign if_rvalid = rsp & ~owner;
    assign d_rvalid  = rsp & owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a response/grant scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam int SM = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 0, d_req = 0, d_we = 0, mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0] d_be = 0;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    typedef struct packed {logic port; logic [31:0] data;} rsp_t;
    rsp_t rsp_q[$];
    rsp_t r;
    logic gnt_q[$];
    int passed = 0, total = 0;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0; if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h44; mem_gnt = 1;
        tick(); #4;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, busy} !== '0)
            $display("FAIL reset_held: mem_req=%b addr=%h gnt=%b%b busy=%b, want all zero", mem_req, mem_addr, if_gnt, d_gnt, busy);
        else passed++;
        d_req = 0;
        tick(); rst_n = 1; #4;
        total++;
        if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL reset_grant: gnt=%b%b, want 10", if_gnt, d_gnt); else passed++;
        tick(); if_req = 0; mem_gnt = 0; #4;
        total++;
        if (busy !== 1'b1) $display("FAIL reset_wait_busy: busy=%b, want 1", busy); else passed++;
        #1 rst_n = 0; #1;
        total++;
        if ({busy, mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid} !== '0)
            $display("FAIL reset_async: busy=%b mem_req=%b, want 0", busy, mem_req);
        else passed++;
        tick(); rst_n = 1;
        tick(); mem_rvalid = 1; mem_rdata = 32'h1234_5678; #4;
        total++;
        if ({if_rvalid, d_rvalid, busy} !== 3'b000)
            $display("FAIL reset_stale_rsp: rvalid=%b%b busy=%b, want 000", if_rvalid, d_rvalid, busy);
        else passed++;
        tick(); mem_rvalid = 0;
    endtask

    task automatic test_single_fetch;
        rsp_q.push_back('{port: 1'b0, data: 32'h0050_0093});
        tick(); if_req = 1; if_addr = 32'h100; mem_gnt = 1; #4;
        total++;
        if ({if_gnt, d_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {4'b1010, 4'b1111, 32'h100, 32'h0})
            $display("FAIL fetch_grant: gnt=%b%b we=%b be=%b addr=%h, want 10 0 1111 00000100", if_gnt, d_gnt, mem_we, mem_be, mem_addr);
        else passed++;
        tick(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093; #4;
        total++;
        if (!(if_rvalid | d_rvalid) || rsp_q.size() == 0) $display("FAIL fetch_rsp: rvalid=%b%b, want a response", if_rvalid, d_rvalid);
        else begin
            r = rsp_q.pop_front();
            if ({d_rvalid, d_rvalid ? d_rdata : if_rdata} !== {r.port, r.data})
                $display("FAIL fetch_rsp: port=%b data=%h, want port=%b data=%h", d_rvalid, if_rdata, r.port, r.data);
            else passed++;
        end
        tick(); mem_rvalid = 0; #4;
        total++;
        if (busy !== 1'b0) $display("FAIL fetch_idle: busy=%b, want 0", busy); else passed++;
    endtask

    task automatic test_collision;
        rsp_q.push_back('{port: 1'b1, data: 32'hDEAD_BEEF});
        rsp_q.push_back('{port: 1'b0, data: 32'h0000_0013});
        tick(); if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 1; d_addr = 32'h2004; d_be = 4'b0011;
        d_wdata = 32'hBEEF; mem_gnt = 1; #4;
        total++;
        if ({if_gnt, d_gnt, mem_we, mem_be, mem_addr, mem_wdata} !== {3'b011, 4'b0011, 32'h2004, 32'hBEEF})
            $display("FAIL collide_data_first: gnt=%b%b we=%b be=%b addr=%h wdata=%h", if_gnt, d_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        else passed++;
        tick(); d_req = 0; d_we = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; #4;
        total++;
        if (!(if_rvalid | d_rvalid) || rsp_q.size() == 0 || if_gnt) $display("FAIL store_rsp: rvalid=%b%b if_gnt=%b", if_rvalid, d_rvalid, if_gnt);
        else begin
            r = rsp_q.pop_front();
            if ({if_rvalid, d_rvalid, d_rvalid ? d_rdata : if_rdata} !== {~r.port, r.port, r.data})
                $display("FAIL store_rsp: rvalid=%b%b data=%h, want port=%b data=%h", if_rvalid, d_rvalid, d_rdata, r.port, r.data);
            else passed++;
        end
        tick(); mem_rvalid = 0; #4;
        total++;
        if ({if_gnt, d_gnt, mem_we, mem_be, mem_addr} !== {3'b100, 4'b1111, 32'h200})
            $display("FAIL collide_fetch_next: gnt=%b%b we=%b addr=%h, want 10 0 00000200", if_gnt, d_gnt, mem_we, mem_addr);
        else passed++;
        tick(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13; #4;
        total++;
        if (!(if_rvalid | d_rvalid) || rsp_q.size() == 0) $display("FAIL collide_fetch_rsp: rvalid=%b%b", if_rvalid, d_rvalid);
        else begin
            r = rsp_q.pop_front();
            if ({d_rvalid, d_rvalid ? d_rdata : if_rdata} !== {r.port, r.data})
                $display("FAIL collide_fetch_rsp: port=%b data=%h, want port=%b data=%h", d_rvalid, if_rdata, r.port, r.data);
            else passed++;
        end
        tick(); mem_rvalid = 0;
    endtask

    task automatic test_hold_lock;
        rsp_q.push_back('{port: 1'b0, data: 32'hA000_0001});
        rsp_q.push_back('{port: 1'b1, data: 32'hB000_0002});
        tick(); if_req = 1; if_addr = 32'h300; mem_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF; end
            #4;
            total++;
            if ({mem_req, if_gnt, d_gnt, mem_addr} !== {3'b100, 32'h300})
                $display("FAIL hold_lock_c%0d: req=%b gnt=%b%b addr=%h, want 100 00000300", c, mem_req, if_gnt, d_gnt, mem_addr);
            else passed++;
            tick();
        end
        mem_gnt = 1; #4;
        total++;
        if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL hold_grant: gnt=%b%b, want 10", if_gnt, d_gnt); else passed++;
        tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'hA000_0001; #4;
        total++;
        if (!(if_rvalid | d_rvalid) || rsp_q.size() == 0) $display("FAIL hold_fetch_rsp: rvalid=%b%b", if_rvalid, d_rvalid);
        else begin
            r = rsp_q.pop_front();
            if ({d_rvalid, d_rvalid ? d_rdata : if_rdata} !== {r.port, r.data})
                $display("FAIL hold_fetch_rsp: port=%b data=%h, want port=%b data=%h", d_rvalid, if_rdata, r.port, r.data);
            else passed++;
        end
        tick(); mem_rvalid = 0; #4;
        total++;
        if ({if_gnt, d_gnt, mem_addr} !== {2'b01, 32'h3000}) $display("FAIL hold_data_next: gnt=%b%b addr=%h", if_gnt, d_gnt, mem_addr); else passed++;
        tick(); d_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hB000_0002; #4;
        total++;
        if (!(if_rvalid | d_rvalid) || rsp_q.size() == 0) $display("FAIL hold_data_rsp: rvalid=%b%b", if_rvalid, d_rvalid);
        else begin
            r = rsp_q.pop_front();
            if ({d_rvalid, d_rvalid ? d_rdata : if_rdata} !== {r.port, r.data})
                $display("FAIL hold_data_rsp: port=%b data=%h, want port=%b data=%h", d_rvalid, d_rdata, r.port, r.data);
            else passed++;
        end
        tick(); mem_rvalid = 0;
    endtask

    task automatic test_back_to_back;
        logic pend = 0;
        int seen = 0;
        for (int i = 0; i < 10; i++)
`ifdef MEM_ARB_FAIRNESS_EN
            gnt_q.push_back((i % (SM + 1)) != SM);
`else
            gnt_q.push_back(1'b1);
`endif
        for (int c = 0; c < 20; c++) begin
            tick(); if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h4000; d_be = 4'hF;
            mem_gnt = 1; mem_rvalid = pend; mem_rdata = 32'(c); #4;
            if (if_gnt | d_gnt) begin
                total++;
                if (gnt_q.size() == 0) $display("FAIL b2b_extra_grant: cycle %0d gnt=%b%b", c, if_gnt, d_gnt);
                else if ({if_gnt, d_gnt} !== {~gnt_q[0], gnt_q[0]})
                    $display("FAIL b2b_order_%0d: gnt=%b%b, want d=%b", seen, if_gnt, d_gnt, gnt_q.pop_front());
                else begin passed++; void'(gnt_q.pop_front()); end
                seen++;
            end
            pend = if_gnt | d_gnt;
        end
        total++;
        if (seen !== 10) $display("FAIL b2b_count: grants=%0d, want 10", seen); else passed++;
        tick(); if_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = pend; #4;
        tick(); mem_rvalid = 0; #4;
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_idle: busy=%b, want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_hold_lock();
        test_back_to_back();
        total++;
        if (rsp_q.size() != 0 || gnt_q.size() != 0)
            $display("FAIL scoreboard_drain: rsp left=%0d gnt left=%0d, want 0", rsp_q.size(), gnt_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
